// File: rtl/clp_inst_sched.sv
// rtl/clp_inst_sched.sv - layer instruction scheduler: fetch, latch, issue and track the layer controller
// Build with CLP_SCHED_WDOG_EN to add the WAIT_ACK/WAIT_DONE watchdog and drive wdog_err.
module clp_inst_sched #(
  parameter int INST_WIDTH      = 100,
  parameter int INST_ADDR_WIDTH = 10,
  parameter int WDOG_CYCLES     = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [INST_ADDR_WIDTH-1:0] prog_base,
  input  logic [INST_ADDR_WIDTH-1:0] prog_len,
  output logic                       inst_rd_en,
  output logic [INST_ADDR_WIDTH-1:0] inst_rd_addr,
  input  logic [INST_WIDTH-1:0]      inst_rd_data,
  output logic                       clp_enable,
  output logic [INST_WIDTH-1:0]      clp_instruction,
  input  logic                       clp_state,
  output logic                       busy,
  output logic                       done,
  output logic [INST_ADDR_WIDTH-1:0] inst_idx,
  output logic                       wdog_err
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, ISSUE, WAIT_ACK, WAIT_DONE, FINISH
  } state_e;

  localparam logic [INST_ADDR_WIDTH-1:0] ADDR_ONE = INST_ADDR_WIDTH'(1);

  state_e                       state_q;
  logic                         start_q;
  logic [INST_ADDR_WIDTH-1:0]   base_q, len_q, idx_q, rd_addr_q;
  logic [INST_ADDR_WIDTH-1:0]   idx_d, last_idx;
  logic [INST_WIDTH-1:0]        inst_q;
  logic                         rd_en_q, enable_q, done_q;
  logic                         start_acc;
  logic                         wdog_trip;

  assign idx_d     = idx_q + ADDR_ONE;
  assign last_idx  = len_q - ADDR_ONE;
  assign start_acc = start && !start_q && (state_q == IDLE);

  // start is registered once so base/len are captured before the FSM acts on them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      rd_addr_q <= '0;
      inst_q    <= '0;
      rd_en_q   <= 1'b0;
      enable_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rd_en_q  <= 1'b0;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_q) begin
            if (len_q != '0) begin
              state_q   <= FETCH;
              idx_q     <= '0;
              rd_en_q   <= 1'b1;
              rd_addr_q <= base_q;
            end else begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end
          end else if (start_acc) begin
            start_q <= 1'b1;
            base_q  <= prog_base;
            len_q   <= prog_len;
          end
        end
        FETCH: state_q <= LATCH;
        LATCH: begin
          inst_q <= inst_rd_data;
          if (inst_rd_data[3:0] == 4'hF) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end else begin
            state_q  <= ISSUE;
            enable_q <= 1'b1;
          end
        end
        ISSUE: state_q <= WAIT_ACK;
        WAIT_ACK: begin
          if (wdog_trip) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end else if (clp_state) begin
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (wdog_trip || (!clp_state && idx_q == last_idx)) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end else if (!clp_state) begin
            state_q   <= FETCH;
            idx_q     <= idx_d;
            rd_en_q   <= 1'b1;
            rd_addr_q <= base_q + idx_d;
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CLP_SCHED_WDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);

  logic [WDW-1:0] wdog_cnt_q;
  logic           wdog_err_q;
  logic           in_wait;

  assign in_wait   = (state_q == WAIT_ACK) || (state_q == WAIT_DONE);
  assign wdog_trip = (wdog_cnt_q == WDW'(WDOG_CYCLES));

  // ISSUE always precedes WAIT_ACK, so clearing there restarts the count on WAIT_ACK entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      if (state_q == ISSUE) begin
        wdog_cnt_q <= '0;
      end else if (in_wait && !wdog_trip) begin
        wdog_cnt_q <= wdog_cnt_q + WDW'(1);
      end
      if (start_acc) begin
        wdog_err_q <= 1'b0;
      end else if (in_wait && wdog_trip) begin
        wdog_err_q <= 1'b1;
      end
    end
  end

  assign wdog_err = wdog_err_q;
`else
  // WDOG_CYCLES only matters when the watchdog is built in; this folds to 0
  assign wdog_trip = (WDOG_CYCLES < 0);
  assign wdog_err  = 1'b0;
`endif

  assign inst_rd_en      = rd_en_q;
  assign inst_rd_addr    = rd_addr_q;
  assign clp_enable      = enable_q;
  assign clp_instruction = inst_q;
  assign done            = done_q;
  assign busy            = (state_q != IDLE);
  assign inst_idx        = idx_q;

endmodule

// File: tb/tb_clp_inst_sched.sv
// tb/tb_clp_inst_sched.sv - directed self-checking bench for clp_inst_sched
module tb_clp_inst_sched;

  localparam int IW   = 100;
  localparam int AW   = 10;
  localparam int WDOG = 64;
`ifdef CLP_SCHED_WDOG_EN
  localparam int BASIC_HOLD = 20;
`else
  localparam int BASIC_HOLD = 788;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] prog_base;
  logic [AW-1:0] prog_len;
  logic          inst_rd_en;
  logic [AW-1:0] inst_rd_addr;
  logic [IW-1:0] inst_rd_data;
  logic          clp_enable;
  logic [IW-1:0] clp_instruction;
  logic          clp_state;
  logic          busy;
  logic          done;
  logic [AW-1:0] inst_idx;
  logic          wdog_err;

  logic [IW-1:0] mem [1024];

  int n_cmp = 0;
  int n_err = 0;
  int ack_dly = 2;
  int hold_cyc = 5;
  bit lc_force = 1'b0;
  int en_cnt = 0, done_cnt = 0, excl_err = 0, min_gap = 1000, last_en = -1, cyc = 0;
  logic [AW-1:0] rd_log [$];
  logic [IW-1:0] en_log [$];

  clp_inst_sched #(
    .INST_WIDTH     (IW),
    .INST_ADDR_WIDTH(AW),
    .WDOG_CYCLES    (WDOG)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .prog_base      (prog_base),
    .prog_len       (prog_len),
    .inst_rd_en     (inst_rd_en),
    .inst_rd_addr   (inst_rd_addr),
    .inst_rd_data   (inst_rd_data),
    .clp_enable     (clp_enable),
    .clp_instruction(clp_instruction),
    .clp_state      (clp_state),
    .busy           (busy),
    .done           (done),
    .inst_idx       (inst_idx),
    .wdog_err       (wdog_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (inst_rd_en) inst_rd_data <= mem[inst_rd_addr];
  end

  // layer controller: ack ack_dly cycles after clp_enable, stay busy for hold_cyc cycles
  initial begin
    clp_state = 1'b0;
    forever begin
      @(negedge clk);
      if (lc_force) begin
        clp_state = 1'b1;
      end else if (clp_enable) begin
        repeat (ack_dly) @(negedge clk);
        clp_state = 1'b1;
        repeat (hold_cyc) @(negedge clk);
        clp_state = 1'b0;
      end else begin
        clp_state = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n === 1'b1) begin
        if (inst_rd_en) rd_log.push_back(inst_rd_addr);
        if (clp_enable) begin
          if (last_en >= 0 && cyc - last_en < min_gap) min_gap = cyc - last_en;
          last_en = cyc;
          en_cnt++;
          en_log.push_back(clp_instruction);
        end
        if (done) done_cnt++;
        if (32'(inst_rd_en) + 32'(clp_enable) + 32'(done) > 1) excl_err++;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [AW-1:0] b, input logic [AW-1:0] l);
    prog_base = b;
    prog_len  = l;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int n);
    n = 1;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
  endtask

  task automatic wait_ack(input string tag);
    int k;
    k = 0;
    while (clp_state !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_ack_seen"}, clp_state, 1'b1);
  endtask

  initial begin
    int n, k, r0, e0, d0, l0;
    for (int i = 0; i < 1024; i++)
      mem[i] = {4'hA, 32'(i * 7 + 1), 32'hC0DE0000 | 32'(i), 28'(i), 4'h5};
    mem[10'h101][3:0] = 4'hF;

    rst_n = 1'b0; start = 1'b0; prog_base = '0; prog_len = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_strobes", {inst_rd_en, clp_enable, done, wdog_err}, 4'b0000);
    check("rst_idx", inst_idx, '0);
    check("rst_inst", clp_instruction, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic run
    ack_dly = 2; hold_cyc = BASIC_HOLD;
    r0 = rd_log.size(); e0 = en_cnt; d0 = done_cnt; l0 = en_log.size();
    launch(10'h010, 10'd3);
    wait_done("basic", 4000, n);
    repeat (3) @(negedge clk);
    check("basic_nrd", rd_log.size() - r0, 3);
    for (int i = 0; i < 3; i++) begin
      check("basic_addr", rd_log[r0 + i], AW'(10'h010 + i));
      check("basic_inst", en_log[l0 + i], mem[10'h010 + i]);
    end
    check("basic_nen", en_cnt - e0, 3);
    check("basic_ndone", done_cnt - d0, 1);
    check("basic_idx", inst_idx, 10'd2);
    check("basic_hold_inst", clp_instruction, mem[10'h012]);
    check("basic_busy", busy, 1'b0);

    // empty program
    hold_cyc = 5;
    r0 = rd_log.size(); e0 = en_cnt; d0 = done_cnt;
    launch(10'h055, 10'd0);
    wait_done("empty", 10, n);
    check("empty_lat", n, 2);
    @(negedge clk);
    check("empty_pulse", done, 1'b0);
    repeat (2) @(negedge clk);
    check("empty_nrd", rd_log.size() - r0, 0);
    check("empty_nen", en_cnt - e0, 0);
    check("empty_ndone", done_cnt - d0, 1);

    // halt opcode at base+1
    r0 = rd_log.size(); e0 = en_cnt; d0 = done_cnt;
    launch(10'h100, 10'd5);
    wait_done("halt", 200, n);
    repeat (3) @(negedge clk);
    check("halt_nrd", rd_log.size() - r0, 2);
    check("halt_nen", en_cnt - e0, 1);
    check("halt_ndone", done_cnt - d0, 1);
    check("halt_idx", inst_idx, 10'd1);
    check("halt_inst", clp_instruction, mem[10'h101]);

    // address wrap
    r0 = rd_log.size(); d0 = done_cnt;
    launch(10'h3FF, 10'd2);
    wait_done("wrap", 200, n);
    repeat (3) @(negedge clk);
    check("wrap_nrd", rd_log.size() - r0, 2);
    check("wrap_addr0", rd_log[r0], 10'h3FF);
    check("wrap_addr1", rd_log[r0 + 1], 10'h000);
    check("wrap_ndone", done_cnt - d0, 1);

    // start while busy
    hold_cyc = 30;
    r0 = rd_log.size(); e0 = en_cnt; d0 = done_cnt;
    launch(10'h020, 10'd2);
    wait_ack("sbusy");
    repeat (3) @(negedge clk);
    launch(10'h200, 10'd7);
    wait_done("sbusy", 300, n);
    repeat (3) @(negedge clk);
    check("sbusy_nrd", rd_log.size() - r0, 2);
    check("sbusy_addr0", rd_log[r0], 10'h020);
    check("sbusy_addr1", rd_log[r0 + 1], 10'h021);
    check("sbusy_nen", en_cnt - e0, 2);
    check("sbusy_ndone", done_cnt - d0, 1);
    check("sbusy_idx", inst_idx, 10'd1);

    // reset in WAIT_DONE
    d0 = done_cnt;
    launch(10'h030, 10'd3);
    wait_ack("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_strobes", {inst_rd_en, clp_enable, done, wdog_err}, 4'b0000);
    check("rstmid_idx", inst_idx, '0);
    check("rstmid_inst", clp_instruction, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rstmid_nodone", done_cnt - d0, 0);
    hold_cyc = 5;
    r0 = rd_log.size(); d0 = done_cnt;
    launch(10'h010, 10'd1);
    wait_done("fresh", 200, n);
    repeat (3) @(negedge clk);
    check("fresh_nrd", rd_log.size() - r0, 1);
    check("fresh_addr", rd_log[r0], 10'h010);
    check("fresh_ndone", done_cnt - d0, 1);

`ifdef CLP_SCHED_WDOG_EN
    lc_force = 1'b1;
    e0 = en_cnt; d0 = done_cnt;
    launch(10'h040, 10'd2);
    k = 0;
    while (!clp_enable && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("wdog_enable_seen", clp_enable, 1'b1);
    k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("wdog_done_seen", done, 1'b1);
    check("wdog_lat_window", (k - 1 >= 65) && (k - 1 <= 66), 1'b1);
    repeat (3) @(negedge clk);
    check("wdog_err_set", wdog_err, 1'b1);
    check("wdog_nen", en_cnt - e0, 1);
    check("wdog_ndone", done_cnt - d0, 1);
    lc_force = 1'b0;
    repeat (3) @(negedge clk);
    launch(10'h050, 10'd0);
    wait_done("wdog_clr", 10, n);
    check("wdog_err_clear", wdog_err, 1'b0);
`else
    lc_force = 1'b1;
    d0 = done_cnt;
    launch(10'h040, 10'd1);
    repeat (200) @(negedge clk);
    check("nowdog_busy", busy, 1'b1);
    check("nowdog_err", wdog_err, 1'b0);
    check("nowdog_nodone", done_cnt - d0, 0);
    lc_force = 1'b0;
    wait_done("nowdog", 20, n);
    repeat (3) @(negedge clk);
    check("nowdog_ndone", done_cnt - d0, 1);
`endif

    check("en_spacing", min_gap >= 4, 1'b1);
    check("strobe_excl", excl_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
